// File: rtl/vector_scale_mc_if.sv
// vector_scale_mc_if: request/response bundle for vector_scale_mc.
//   start   : request strobe, sampled while the block is idle
//   scalar  : multiplier s
//   vec     : operand vector x[0..N-1]
//   addend  : AXPY addend y[0..N-1] (only with VECTOR_SCALE_MC_AXPY_EN)
//   result  : registered result vector r[0..N-1]
//   busy    : operation in flight
//   done    : one-cycle completion pulse
//   valid   : result holds a complete vector
// master = requester, slave = vector_scale_mc.
interface vector_scale_mc_if #(
  parameter int unsigned WORD_WIDTH  = 31,
  parameter int unsigned VECTOR_SIZE = 16
);
  logic                                   start;
  logic [WORD_WIDTH-1:0]                  scalar;
  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec;
`ifdef VECTOR_SCALE_MC_AXPY_EN
  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] addend;
`endif
  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] result;
  logic                                   busy;
  logic                                   done;
  logic                                   valid;

`ifdef VECTOR_SCALE_MC_AXPY_EN
  modport master (output start, scalar, vec, addend, input result, busy, done, valid);
  modport slave  (input start, scalar, vec, addend, output result, busy, done, valid);
`else
  modport master (output start, scalar, vec, input result, busy, done, valid);
  modport slave  (input start, scalar, vec, output result, busy, done, valid);
`endif
endinterface

// File: rtl/vector_scale_mc.sv
// vector_scale_mc: multi-cycle vector scale over the Mersenne field p = 2^W-1.
//   r[k] = (s * x[k]) mod p, one element issued per cycle into a
//   MUL_PIPELINE_STAGES-deep multiplier; done fires N+P+1 edges after start.
// Optional feature macro: VECTOR_SCALE_MC_AXPY_EN adds bus.addend and computes
//   r[k] = (s * x[k] + y[k]) mod p with identical latency.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : vector_scale_mc_if.slave (start/scalar/vec[/addend] in,
//           result/busy/done/valid out, all outputs registered)
module vector_scale_mc #(
  parameter int unsigned WORD_WIDTH          = 31,
  parameter int unsigned VECTOR_SIZE         = 16,
  parameter int unsigned MUL_PIPELINE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  vector_scale_mc_if.slave  bus
);
  localparam int unsigned W       = WORD_WIDTH;
  localparam int unsigned N       = VECTOR_SIZE;
  localparam int unsigned P       = MUL_PIPELINE_STAGES;
  localparam int unsigned PROD_W  = 2 * W;
  localparam int unsigned FOLD_W  = W + 2;
  localparam int unsigned RED_W   = W + 1;
  localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_MAX = (N > P) ? N : P;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [W-1:0] MOD_P  = {W{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // One in-flight element: first fold of the product (plus addend) and its index.
  typedef struct packed {
    logic              vld;
    logic [IDX_W-1:0]  idx;
    logic [FOLD_W-1:0] fold;
  } stage_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    accept_c, issue_c, busy_d, done_d;
  logic                    busy_q, done_q, valid_q;
  logic [W-1:0]            s_q;
  logic [N-1:0][W-1:0]     x_q;
`ifdef VECTOR_SCALE_MC_AXPY_EN
  logic [N-1:0][W-1:0]     y_q;
  logic [W-1:0]            y_sel;
`endif
  logic [N-1:0][W-1:0]     result_q;
  logic [IDX_W-1:0]        cnt_idx;
  logic [W-1:0]            x_sel;
  logic [PROD_W-1:0]       prod;
  stage_t                  iss, tail;
  logic [RED_W-1:0]        fold2;
  logic [W-1:0]            canon;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = ISSUE;
      ISSUE: if (cnt_q == CNT_W'(N - 1)) state_d = DRAIN;
      DRAIN: if (cnt_q == CNT_W'(P - 1)) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  // FSM decodes; busy/done are registered below so they lag the state by one edge
  always_comb begin
    accept_c = 1'b0;
    issue_c  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE:  accept_c = bus.start;
      ISSUE: begin issue_c = 1'b1; busy_d = 1'b1; end
      DRAIN: busy_d = 1'b1;
      DONE:  done_d = 1'b1;
    endcase
  end

  // Shared element / drain counter, restarts on every state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else if (busy_d)             cnt_q <= cnt_q + CNT_W'(1);
  end

  // Operand capture at acceptance; later input changes are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q <= '0;
      x_q <= '0;
`ifdef VECTOR_SCALE_MC_AXPY_EN
      y_q <= '0;
`endif
    end else if (accept_c) begin
      s_q <= bus.scalar;
      x_q <= bus.vec;
`ifdef VECTOR_SCALE_MC_AXPY_EN
      y_q <= bus.addend;
`endif
    end
  end

  // Issue stage: select x[k], multiply, first fold (lo + hi [+ y])
  always_comb begin
    cnt_idx = IDX_W'(cnt_q);
    x_sel   = '0;
`ifdef VECTOR_SCALE_MC_AXPY_EN
    y_sel   = '0;
`endif
    for (int k = 0; k < int'(N); k++) begin
      if (cnt_idx == IDX_W'(k)) begin
        x_sel = x_q[k];
`ifdef VECTOR_SCALE_MC_AXPY_EN
        y_sel = y_q[k];
`endif
      end
    end
    prod     = PROD_W'(s_q) * PROD_W'(x_sel);
    iss.vld  = issue_c;
    iss.idx  = cnt_idx;
    iss.fold = FOLD_W'(prod[W-1:0]) + FOLD_W'(prod[PROD_W-1:W])
`ifdef VECTOR_SCALE_MC_AXPY_EN
             + FOLD_W'(y_sel)
`endif
             ;
  end

  // Multiplier pipeline: P-1 registers, the result register is the last stage
  generate
    if (P == 1) begin : g_nopipe
      assign tail = iss;
    end else begin : g_pipe
      stage_t pipe [P-1];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < int'(P) - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= iss;
          for (int i = 1; i < int'(P) - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign tail = pipe[P-2];
    end
  endgenerate

  // Second fold then canonicalise; fold2 never exceeds p+3, one subtract suffices
  always_comb begin
    fold2 = RED_W'(tail.fold[W-1:0]) + RED_W'(tail.fold[FOLD_W-1:W]);
    canon = (fold2 >= RED_W'(MOD_P)) ? W'(fold2 - RED_W'(MOD_P)) : W'(fold2);
  end

  // Result vector: elements written in index order, held between operations
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
    end else if (tail.vld) begin
      for (int k = 0; k < int'(N); k++) begin
        if (tail.idx == IDX_W'(k)) result_q[k] <= canon;
      end
    end
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept_c)    valid_q <= 1'b0;
      else if (done_d) valid_q <= 1'b1;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.valid  = valid_q;

endmodule
